prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the multicycle RISC-V `cpu` and its unified instruction/data memory. It accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. It writes each word into memory at consecutive word addresses and holds the core in reset until the image is complete. It then releases `cpu_rst` after a programmable hold time and flags `done`.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first written word.
- `WORDS`, default 256: maximum number of words the image may contain.
- `RST_HOLD`, default 2: number of cycles spent in RELEASE, with `cpu_rst` still high, after the last write. Must be at least 1.
- `CW = $clog2(WORDS+1)` (localparam): width of `word_count`.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: `in_data` holds a valid byte.
- `in_data`, input, 8: stream byte.
- `in_last`, input, 1: the current byte is the final byte of the image. Sampled only on an accepted byte.
- `in_ready`, output, 1: the loader accepts a byte this cycle.
- `mem_we`, output, 1: one-cycle memory write strobe.
- `mem_addr`, output, 32: memory byte address, word aligned.
- `mem_wdata`, output, 32: memory write data.
- `cpu_rst`, output, 1: drives the core's `rst`; high in every state except RUN.
- `done`, output, 1: the image is loaded and the core has been released.
- `err`, output, 1: overflow occurred; sticky until `rst`.
- `word_count`, output, CW: number of words written so far.

## Operation
- States: LOAD, WRITE, RELEASE, RUN, ERROR. Reset enters LOAD.
- A byte is accepted when `in_valid && in_ready`.
- `in_ready` is 1 only in LOAD. It is decoded from the registered state.
- Packing in LOAD:
  - A 2-bit byte index `bidx` places each accepted byte at bits `[8*bidx+7 : 8*bidx]` of the word buffer, then increments `bidx`.
  - Byte 0 is the least significant byte.
- An accepted byte moves the FSM to WRITE when either `bidx==3` or `in_last==1`.
  - On `in_last` with `bidx<3`, the unfilled upper bytes are zero.
  - The FSM latches `last_seen = in_last`.
- WRITE lasts exactly 1 cycle:
  - `mem_we=1`.
  - `mem_addr = BASE_ADDR + 4*word_count` (value before the increment).
  - `mem_wdata` = the buffer.
  - At the end of the cycle: `word_count` increments, the buffer clears to 0, `bidx` clears to 0.
  - Next state is RELEASE if `last_seen`, otherwise LOAD.
- Overflow: in LOAD with `word_count==WORDS`, an accepted byte is discarded.
  - The FSM goes to ERROR; no write occurs.
  - ERROR is terminal until `rst`: `err=1`, `in_ready=0`, `cpu_rst=1`, `done=0`.
- RELEASE: a hold counter runs for exactly `RST_HOLD` cycles, then the FSM goes to RUN.
- RUN is terminal until `rst`: `cpu_rst=0`, `done=1`, `in_ready=0`, `mem_we=0`.
- `mem_addr` and `mem_wdata` are registered and hold their last values outside WRITE. `mem_we` is 0 outside WRITE.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. This case is not expected in practice.

## Timing
- Reset values, in the cycle after an edge with `rst=1`:
  - State LOAD, `in_ready=1`.
  - `mem_we=0`, `mem_addr=BASE_ADDR`, `mem_wdata=0`.
  - `cpu_rst=1`, `done=0`, `err=0`, `word_count=0`.
  - `bidx=0`, buffer 0, hold counter 0.
- Latency: the byte that completes a word is accepted at edge N. `mem_we` is high during cycle N..N+1, and `in_ready` is low in that same cycle.
- Throughput: at most 4 bytes per 5 cycles.
- Stalls: `in_valid=0` cycles are ignored. There is no timeout, and partial words are held indefinitely.
- Release timing: the last write cycle is W. RELEASE occupies the next `RST_HOLD` cycles. `cpu_rst` falls and `done` rises in cycle W+1+RST_HOLD.
- Reset mid-operation: `rst` in any state, including WRITE, RUN or ERROR, returns everything to the reset values at that edge.
  - A WRITE cycle coinciding with `rst` still presents `mem_we=1` for that cycle.
  - The `word_count` increment for that write is lost.
- `rst` has priority over a simultaneous byte acceptance.

## Test plan
- **Full load:** bytes 13 05 50 00 93 05 60 00, with `in_last` on byte 8, `RST_HOLD=2`.
  - Writes: 0x00500513 at address 0x0, then 0x00600593 at address 0x4.
  - `word_count=2`.
  - `cpu_rst` falls and `done` rises 3 cycles after the second `mem_we`.
- **Partial final word:** bytes AA BB CC DD 11 22, with `in_last` on 22.
  - Writes: 0xDDCCBBAA at address 0x0, then 0x00002211 at address 0x4.
- **Gapped valid:** the 4-byte word 0xDEADBEEF arrives with `in_valid` low for 3 cycles between each byte.
  - Exactly one write of 0xDEADBEEF.
  - `in_ready` is low only during the WRITE cycle.
- **Overflow, `WORDS=2`:** 9 bytes with no `in_last`.
  - Two writes occur, then `err=1` after byte 9.
  - No third `mem_we`; `in_ready=0`; `cpu_rst` stays 1.
- **Reset mid-load:** `rst` after 2 bytes, then bytes 01 02 03 04 with `in_last`.
  - Single write of 0x04030201 at `BASE_ADDR`.
  - `word_count=1`.
- **Reset in RUN:** `cpu_rst=1`, `done=0`, `in_ready=1` in the cycle after the `rst` edge. A new image then loads normally.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: packs a byte stream into little-endian words, writes them to memory,
// then releases the core from reset after a fixed hold time.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 256,
  parameter int unsigned RST_HOLD  = 2,
  localparam int unsigned CW       = $clog2(WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] word_count
);

  localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {StLoad, StWrite, StRelease, StRun, StError} state_e;

  state_e        state_q, state_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   buf_q, buf_d;
  logic          last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   word_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      bidx_q  <= 2'd0;
      buf_q   <= 32'd0;
      last_q  <= 1'b0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
    end
  end

  // Buffer with the incoming byte merged at its lane
  always_comb begin
    word_new = buf_q;
    unique case (bidx_q)
      2'd0: word_new[7:0]   = in_data;
      2'd1: word_new[15:8]  = in_data;
      2'd2: word_new[23:16] = in_data;
      2'd3: word_new[31:24] = in_data;
      default: word_new = buf_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    buf_d   = buf_q;
    last_d  = last_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (count_q == CW'(WORDS)) begin
            state_d = StError;
          end else begin
            buf_d  = word_new;
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3 || in_last) begin
              state_d = StWrite;
              last_d  = in_last;
              addr_d  = BASE_ADDR + (32'(count_q) << 2);
              wdata_d = word_new;
            end
          end
        end
      end
      StWrite: begin
        count_d = count_q + CW'(1);
        buf_d   = 32'd0;
        bidx_d  = 2'd0;
        hold_d  = '0;
        state_d = last_q ? StRelease : StLoad;
      end
      StRelease: begin
        if (hold_q == HW'(RST_HOLD - 1)) state_d = StRun;
        else                             hold_d  = hold_q + HW'(1);
      end
      StRun, StError: ;
      default: state_d = StLoad;
    endcase
  end

  assign in_ready   = (state_q == StLoad);
  assign mem_we     = (state_q == StWrite);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rst    = (state_q != StRun);
  assign done       = (state_q == StRun);
  assign err        = (state_q == StError);
  assign word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a cycle-level image-loading model checked every cycle, plus
// directed image scenarios with literal expected writes and timings.
module tb_prog_loader;

  localparam int unsigned WORDS_P = 2;
  localparam int unsigned RH      = 2;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int unsigned CW      = $clog2(WORDS_P + 1);

  logic          clk, rst, in_valid, in_last;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_rst, done, err;
  logic [31:0]   mem_addr, mem_wdata;
  logic [CW-1:0] word_count;

  prog_loader #(
    .BASE_ADDR (BASE),
    .WORDS     (WORDS_P),
    .RST_HOLD  (RH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes collected so far, pending write, remaining hold cycles, terminal flags
  bit          armed = 0;
  logic [7:0]  m_bytes[$];
  bit          m_wr, m_last, m_done, m_err;
  int          m_cnt, m_rel;
  logic [31:0] m_addr, m_wdata, w;

  always @(posedge clk) begin
    if (rst) begin
      armed = 1; m_wr = 0; m_last = 0; m_done = 0; m_err = 0;
      m_cnt = 0; m_rel = 0; m_addr = BASE; m_wdata = 0;
      m_bytes.delete();
    end else if (armed) begin
      if (m_wr) begin
        m_wr = 0;
        m_cnt++;
        if (m_last) m_rel = RH;
      end else if (m_rel > 0) begin
        m_rel--;
        if (m_rel == 0) m_done = 1;
      end else if (in_valid && !m_done && !m_err) begin
        if (m_cnt == WORDS_P) begin
          m_err = 1;
        end else begin
          m_bytes.push_back(in_data);
          if (m_bytes.size() == 4 || in_last) begin
            w = 0;
            foreach (m_bytes[i]) w |= 32'(m_bytes[i]) << (8 * i);
            m_wdata = w;
            m_addr  = BASE + 32'(4 * m_cnt);
            m_wr    = 1;
            m_last  = in_last;
            m_bytes.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready",   32'(in_ready),   32'(!m_wr && m_rel == 0 && !m_done && !m_err));
      check("mem_we",     32'(mem_we),     32'(m_wr));
      check("mem_addr",   mem_addr,        m_addr);
      check("mem_wdata",  mem_wdata,       m_wdata);
      check("cpu_rst",    32'(cpu_rst),    32'(!m_done));
      check("done",       32'(done),       32'(m_done));
      check("err",        32'(err),        32'(m_err));
      check("word_count", 32'(word_count), 32'(m_cnt));
    end
  end

  // Write log and timing marks taken from the DUT for the literal checks
  logic [31:0] log_a[$], log_d[$];
  int cyc = 0, last_wr = 0, done_at = 0, nr = 0;
  bit done_prev = 0, win = 0;

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
      last_wr = cyc;
    end
    if (done && !done_prev) done_at = cyc;
    done_prev = done;
    if (win && !in_ready) nr++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    in_valid = 1; in_data = d; in_last = last;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("handshake ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("done reached", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (log_d.size() > idx) begin
      check("write addr", log_a[idx], a);
      check("write data", log_d[idx], d);
    end
  endtask

  logic [7:0] img_full[8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
  logic [7:0] img_part[6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
  logic [7:0] img_gap[4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    rst = 1; in_valid = 0; in_data = 8'h00; in_last = 0;
    idle(2);
    rst = 0;
    check("reset in_ready",   32'(in_ready),   32'd1);
    check("reset cpu_rst",    32'(cpu_rst),    32'd1);
    check("reset word_count", 32'(word_count), 32'd0);
    check("reset mem_addr",   mem_addr,        BASE);
    check("reset mem_wdata",  mem_wdata,       32'd0);

    // Full two-word image
    clear_log();
    foreach (img_full[i]) send(img_full[i], i == 7);
    wait_done();
    check("full writes", 32'(log_d.size()), 32'd2);
    check_write(0, 32'h0, 32'h0050_0513);
    check_write(1, 32'h4, 32'h0060_0593);
    check("full word_count", 32'(word_count), 32'd2);
    check("full release delay", 32'(done_at - last_wr), 32'd3);

    // Partial final word
    do_reset();
    clear_log();
    foreach (img_part[i]) send(img_part[i], i == 5);
    wait_done();
    check("partial writes", 32'(log_d.size()), 32'd2);
    check_write(0, 32'h0, 32'hDDCC_BBAA);
    check_write(1, 32'h4, 32'h0000_2211);

    // Gapped valid, no in_last: one write, ready low only in the write cycle
    do_reset();
    clear_log();
    nr = 0; win = 1;
    foreach (img_gap[i]) begin
      send(img_gap[i], 1'b0);
      if (i < 3) idle(3);
    end
    idle(2);
    win = 0;
    check("gap writes", 32'(log_d.size()), 32'd1);
    check_write(0, 32'h0, 32'hDEAD_BEEF);
    check("gap not-ready cycles", 32'(nr), 32'd1);

    // Reset coinciding with a write cycle loses the count increment
    do_reset();
    for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
    check("write-cycle mem_we", 32'(mem_we), 32'd1);
    do_reset();
    check("write-reset word_count", 32'(word_count), 32'd0);

    // Overflow with WORDS=2
    do_reset();
    clear_log();
    for (int i = 0; i < 9; i++) send(8'(i), 1'b0);
    idle(3);
    check("ovf writes", 32'(log_d.size()), 32'd2);
    check_write(0, 32'h0, 32'h0302_0100);
    check_write(1, 32'h4, 32'h0706_0504);
    check("ovf err",      32'(err),      32'd1);
    check("ovf in_ready", 32'(in_ready), 32'd0);
    check("ovf cpu_rst",  32'(cpu_rst),  32'd1);

    // Reset mid-load
    do_reset();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) send(8'(i + 1), i == 3);
    wait_done();
    check("midload writes", 32'(log_d.size()), 32'd1);
    check_write(0, BASE, 32'h0403_0201);
    check("midload word_count", 32'(word_count), 32'd1);

    // Reset in RUN, then a fresh image
    do_reset();
    check("run-reset cpu_rst",  32'(cpu_rst),  32'd1);
    check("run-reset done",     32'(done),     32'd0);
    check("run-reset in_ready", 32'(in_ready), 32'd1);
    clear_log();
    send(8'h78, 1'b0);
    send(8'h56, 1'b0);
    send(8'h34, 1'b0);
    send(8'h12, 1'b1);
    wait_done();
    check("reload writes", 32'(log_d.size()), 32'd1);
    check_write(0, 32'h0, 32'h1234_5678);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
